// File: rtl/de_issue_ctrl.sv
// Decode-stage issue controller: per-GPR pending-write scoreboard, inflight
// limiter and a two-state RUN/DRAIN flush sequencer.
module de_issue_ctrl #(
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       de_v,
   input  logic [2:0] de_src1,
   input  logic       de_src1_v,
   input  logic [2:0] de_src2,
   input  logic       de_src2_v,
   input  logic [2:0] de_dst,
   input  logic       de_dst_we,
   input  logic       mem_dep,
   input  logic       mr_stall,
   input  logic       mw_stall,
   input  logic       wb_v,
   input  logic [2:0] wb_reg,
   input  logic       wb_we,
   input  logic       flush,
   output logic       ld_ag,
   output logic       reg_dep,
   output logic       ag_vin,
   output logic       de_stall,
   output logic [7:0] busy,
   output logic [2:0] inflight,
   output logic       draining,
   output logic       sb_err
);

   localparam logic [0:0] StRun   = 1'b0;
   localparam logic [0:0] StDrain = 1'b1;

   logic [1:0] cnt_q [8];
   logic [1:0] cnt_d [8];
   logic [2:0] inflight_q, inflight_d;
   logic [0:0] state_q, state_d;
   logic       sb_err_q, sb_err_d;
   logic [7:0] cnt_inc, cnt_dec;
   logic       issue;
   logic       inf_dec;
   logic       wb_err;

   // Busy flags decode straight from the counter flops, so writeback only
   // releases a hazard on the following cycle.
   always_comb begin
      busy = '0;
      for (int i = 0; i < 8; i++) begin
         busy[i] = (cnt_q[i] != 2'd0);
      end
   end

   assign ld_ag   = ~(mem_dep | mr_stall | mw_stall);
   // A destination whose counter is saturated must wait, otherwise it would wrap.
   assign reg_dep = de_v & ((de_src1_v & busy[de_src1]) | (de_src2_v & busy[de_src2]) |
                            (de_dst_we & (cnt_q[de_dst] == 2'd3)));
   assign issue   = de_v & ~reg_dep & ld_ag & (state_q == StRun) & ~flush &
                    (32'(inflight_q) < MAX_INFLIGHT);
   assign ag_vin   = issue;
   assign de_stall = de_v & ~issue & ~flush;

   // Per-register increment/decrement requests; a decrement of an empty
   // counter is dropped and reported instead.
   always_comb begin
      cnt_inc = '0;
      cnt_dec = '0;
      for (int i = 0; i < 8; i++) begin
         cnt_inc[i] = issue & de_dst_we & (de_dst == 3'(i));
         cnt_dec[i] = wb_v & wb_we & (wb_reg == 3'(i)) & (cnt_q[i] != 2'd0);
      end
   end

   // Next-state counters; simultaneous inc and dec cancel.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_inc[i] && !cnt_dec[i]) begin
            cnt_d[i] = cnt_q[i] + 2'd1;
         end else if (!cnt_inc[i] && cnt_dec[i]) begin
            cnt_d[i] = cnt_q[i] - 2'd1;
         end
      end
   end

   assign inf_dec = wb_v & (inflight_q != 3'd0);
   assign wb_err  = (wb_v & (inflight_q == 3'd0)) |
                    (wb_v & wb_we & (cnt_q[wb_reg] == 2'd0));

   // Next-state inflight count and sticky error.
   always_comb begin
      inflight_d = inflight_q;
      if (issue && !inf_dec) begin
         inflight_d = inflight_q + 3'd1;
      end else if (!issue && inf_dec) begin
         inflight_d = inflight_q - 3'd1;
      end
      sb_err_d = sb_err_q | wb_err;
   end

   // RUN/DRAIN sequencing; leave DRAIN once nothing will remain in flight.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun: begin
            if (flush) state_d = StDrain;
         end
         default: begin
            if ((inflight_d == 3'd0) && !flush) state_d = StRun;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= 2'd0;
         end
         inflight_q <= 3'd0;
         state_q    <= StRun;
         sb_err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         inflight_q <= inflight_d;
         state_q    <= state_d;
         sb_err_q   <= sb_err_d;
      end
   end

   assign inflight = inflight_q;
   assign draining = (state_q == StDrain);
   assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_de_issue_ctrl.sv
// Scoreboard bench for de_issue_ctrl: the stimulus process pushes the
// hand-computed outputs for each cycle; the monitor pops and compares them.
module tb_de_issue_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       de_v, de_src1_v, de_src2_v, de_dst_we;
   logic [2:0] de_src1, de_src2, de_dst, wb_reg;
   logic       mem_dep, mr_stall, mw_stall;
   logic       wb_v, wb_we, flush;
   logic       ld_ag, reg_dep, ag_vin, de_stall, draining, sb_err;
   logic [7:0] busy;
   logic [2:0] inflight;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      string      nm;
      logic       ag, dep, stall, ld;
      logic [7:0] busy;
      logic [2:0] inf;
      logic       dr, err;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   de_issue_ctrl #(.MAX_INFLIGHT(4)) dut (
      .clk(clk), .reset_n(reset_n), .de_v(de_v),
      .de_src1(de_src1), .de_src1_v(de_src1_v), .de_src2(de_src2), .de_src2_v(de_src2_v),
      .de_dst(de_dst), .de_dst_we(de_dst_we),
      .mem_dep(mem_dep), .mr_stall(mr_stall), .mw_stall(mw_stall),
      .wb_v(wb_v), .wb_reg(wb_reg), .wb_we(wb_we), .flush(flush),
      .ld_ag(ld_ag), .reg_dep(reg_dep), .ag_vin(ag_vin), .de_stall(de_stall),
      .busy(busy), .inflight(inflight), .draining(draining), .sb_err(sb_err)
   );

   task automatic chk(input string nm, input string fld, input logic [7:0] act,
                      input logic [7:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
   endtask

   // Monitor: every cycle presented by the stimulus is checked mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.nm, "ag_vin",   {7'd0, ag_vin},   {7'd0, e.ag});
         chk(e.nm, "reg_dep",  {7'd0, reg_dep},  {7'd0, e.dep});
         chk(e.nm, "de_stall", {7'd0, de_stall}, {7'd0, e.stall});
         chk(e.nm, "ld_ag",    {7'd0, ld_ag},    {7'd0, e.ld});
         chk(e.nm, "busy",     busy,             e.busy);
         chk(e.nm, "inflight", {5'd0, inflight}, {5'd0, e.inf});
         chk(e.nm, "draining", {7'd0, draining}, {7'd0, e.dr});
         chk(e.nm, "sb_err",   {7'd0, sb_err},   {7'd0, e.err});
      end
   end

   // One cycle: drive inputs after the edge, queue the expected outputs.
   // stl = {mem_dep, mr_stall, mw_stall}
   task automatic cyc(input string nm, input logic rst, input logic dv,
                      input logic [2:0] s1, input logic s1v, input logic [2:0] d,
                      input logic dwe, input logic [2:0] stl, input logic wv,
                      input logic [2:0] wr, input logic wwe, input logic fl,
                      input logic e_ag, input logic e_dep, input logic e_stall,
                      input logic e_ld, input logic [7:0] e_busy, input logic [2:0] e_inf,
                      input logic e_dr, input logic e_err);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n = rst; de_v = dv; de_src1 = s1; de_src1_v = s1v;
      de_src2 = 3'd0; de_src2_v = 1'b0; de_dst = d; de_dst_we = dwe;
      {mem_dep, mr_stall, mw_stall} = stl;
      wb_v = wv; wb_reg = wr; wb_we = wwe; flush = fl;
      e.nm = nm; e.ag = e_ag; e.dep = e_dep; e.stall = e_stall; e.ld = e_ld;
      e.busy = e_busy; e.inf = e_inf; e.dr = e_dr; e.err = e_err;
      exp_q.push_back(e);
   endtask

   initial begin
      reset_n = 1'b0; de_v = 1'b0; de_src1 = '0; de_src1_v = 1'b0; de_src2 = '0;
      de_src2_v = 1'b0; de_dst = '0; de_dst_we = 1'b0; mem_dep = 1'b0; mr_stall = 1'b0;
      mw_stall = 1'b0; wb_v = 1'b0; wb_reg = '0; wb_we = 1'b0; flush = 1'b0;
      //  name       rst dv s1 s1v d dwe stl   wv wr wwe fl | ag dep stl ld busy inf dr err
      cyc("rst_a",    0, 1, 0, 0, 1, 1, 3'b000, 1, 1, 1, 0,  1, 0, 0, 1, 8'h00, 0, 0, 0);
      cyc("rst_b",    0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 1,  0, 0, 0, 1, 8'h00, 0, 0, 0);
      // RAW hazard on r1, released by writeback one cycle later
      cyc("iss_r1",   1, 1, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0,  1, 0, 0, 1, 8'h00, 0, 0, 0);
      cyc("raw_stl",  1, 1, 1, 1, 3, 1, 3'b000, 0, 0, 0, 0,  0, 1, 1, 1, 8'h02, 1, 0, 0);
      cyc("raw_wb",   1, 1, 1, 1, 3, 1, 3'b000, 1, 1, 1, 0,  0, 1, 1, 1, 8'h02, 1, 0, 0);
      cyc("raw_rel",  1, 1, 1, 1, 3, 1, 3'b000, 0, 0, 0, 0,  1, 0, 0, 1, 8'h00, 0, 0, 0);
      // Fill to the inflight limit
      cyc("fill4",    1, 1, 0, 0, 4, 1, 3'b000, 0, 0, 0, 0,  1, 0, 0, 1, 8'h08, 1, 0, 0);
      cyc("fill5",    1, 1, 0, 0, 5, 1, 3'b000, 0, 0, 0, 0,  1, 0, 0, 1, 8'h18, 2, 0, 0);
      cyc("fill6",    1, 1, 0, 0, 6, 1, 3'b000, 0, 0, 0, 0,  1, 0, 0, 1, 8'h38, 3, 0, 0);
      cyc("full_a",   1, 1, 0, 0, 7, 1, 3'b000, 0, 0, 0, 0,  0, 0, 1, 1, 8'h78, 4, 0, 0);
      cyc("full_b",   1, 1, 0, 0, 7, 1, 3'b000, 0, 0, 0, 0,  0, 0, 1, 1, 8'h78, 4, 0, 0);
      cyc("full_wb",  1, 1, 0, 0, 7, 1, 3'b000, 1, 3, 1, 0,  0, 0, 1, 1, 8'h78, 4, 0, 0);
      cyc("full_rel", 1, 1, 0, 0, 7, 1, 3'b000, 0, 0, 0, 0,  1, 0, 0, 1, 8'h70, 3, 0, 0);
      cyc("ret4",     1, 0, 0, 0, 0, 0, 3'b000, 1, 4, 1, 0,  0, 0, 0, 1, 8'hf0, 4, 0, 0);
      cyc("ret5",     1, 0, 0, 0, 0, 0, 3'b000, 1, 5, 1, 0,  0, 0, 0, 1, 8'he0, 3, 0, 0);
      // Same-cycle issue and retire of r2 cancels
      cyc("iss_r2",   1, 1, 0, 0, 2, 1, 3'b000, 0, 0, 0, 0,  1, 0, 0, 1, 8'hc0, 2, 0, 0);
      cyc("r2_both",  1, 1, 0, 0, 2, 1, 3'b000, 1, 2, 1, 0,  1, 0, 0, 1, 8'hc4, 3, 0, 0);
      cyc("ret6",     1, 0, 0, 0, 0, 0, 3'b000, 1, 6, 1, 0,  0, 0, 0, 1, 8'hc4, 3, 0, 0);
      // Flush with two in flight, drain over two writebacks
      cyc("flush2",   1, 1, 0, 0, 0, 1, 3'b000, 0, 0, 0, 1,  0, 0, 0, 1, 8'h84, 2, 0, 0);
      cyc("drain_a",  1, 1, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0,  0, 0, 1, 1, 8'h84, 2, 1, 0);
      cyc("drain_b",  1, 1, 0, 0, 0, 1, 3'b000, 1, 7, 1, 0,  0, 0, 1, 1, 8'h84, 2, 1, 0);
      cyc("drain_c",  1, 1, 0, 0, 0, 1, 3'b000, 1, 2, 1, 0,  0, 0, 1, 1, 8'h04, 1, 1, 0);
      cyc("resume",   1, 1, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0,  1, 0, 0, 1, 8'h00, 0, 0, 0);
      cyc("ret0",     1, 0, 0, 0, 0, 0, 3'b000, 1, 0, 1, 0,  0, 0, 0, 1, 8'h01, 1, 0, 0);
      // Flush with nothing in flight: one DRAIN cycle
      cyc("flush0",   1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1,  0, 0, 0, 1, 8'h00, 0, 0, 0);
      cyc("drain1",   1, 1, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0,  0, 0, 1, 1, 8'h00, 0, 1, 0);
      cyc("mr_stl",   1, 1, 0, 0, 1, 1, 3'b010, 0, 0, 0, 0,  0, 0, 1, 0, 8'h00, 0, 0, 0);
      // Flush repeated while draining holds DRAIN
      cyc("fl_a",     1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1,  0, 0, 0, 1, 8'h00, 0, 0, 0);
      cyc("fl_b",     1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1,  0, 0, 0, 1, 8'h00, 0, 1, 0);
      cyc("fl_c",     1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 1, 8'h00, 0, 1, 0);
      cyc("fl_end",   1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 1, 8'h00, 0, 0, 0);
      cyc("md_stl",   1, 1, 0, 0, 1, 1, 3'b100, 0, 0, 0, 0,  0, 0, 1, 0, 8'h00, 0, 0, 0);
      cyc("mw_stl",   1, 1, 0, 0, 1, 1, 3'b001, 0, 0, 0, 0,  0, 0, 1, 0, 8'h00, 0, 0, 0);
      // Underflow error is sticky until reset
      cyc("uflow",    1, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0,  0, 0, 0, 1, 8'h00, 0, 0, 0);
      cyc("err_a",    1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 1, 8'h00, 0, 0, 1);
      cyc("err_b",    1, 0, 0, 0, 0, 0, 3'b000, 1, 3, 1, 0,  0, 0, 0, 1, 8'h00, 0, 0, 1);
      cyc("err_rst",  0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 1, 8'h00, 0, 0, 1);
      // Saturated destination counter blocks issue
      cyc("sat1",     1, 1, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0,  1, 0, 0, 1, 8'h00, 0, 0, 0);
      cyc("sat2",     1, 1, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0,  1, 0, 0, 1, 8'h02, 1, 0, 0);
      cyc("sat3",     1, 1, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0,  1, 0, 0, 1, 8'h02, 2, 0, 0);
      cyc("sat_blk",  1, 1, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0,  0, 1, 1, 1, 8'h02, 3, 0, 0);
      begin
         int guard = 0;
         while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
         end
         @(posedge clk);
         if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
